alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_cmd_fifo.sv | 45 ++++
 rtl/alu_issue_stage.sv | 105 ++++++++++
 tb/tb_alu_issue_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, command entry struct and issue-stage FSM states.
package alu_pkg;
    localparam int OP_W   = 3;
    localparam int OPND_W = 4;
    localparam int RES_W  = 8;
    typedef logic [OP_W-1:0]   op_t;
    typedef logic [OPND_W-1:0] opnd_t;
    typedef logic [RES_W-1:0]  res_t;
    typedef struct packed {
        opnd_t a;
        opnd_t b;
        op_t   op;
    } cmd_t;
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: command FIFO; push is refused when full, pop ignored when empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  cmd_t                     i_data,
    input  logic                     i_pop,
    output cmd_t                     o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    cmd_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= i_data;
    // Pointers are AW bits wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= w_push ? r_wr + 1'b1 : r_wr;
            r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
            r_count <= (w_push && !w_pop) ? r_count + 1'b1 :
                       (!w_push && w_pop) ? r_count - 1'b1 : r_count;
        end
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: queues ALU commands, issues one at a time, waits ALU_LAT
// cycles, then holds the captured result until the consumer takes it.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPND_W-1:0]      in_a,
    input  logic [OPND_W-1:0]      in_b,
    input  logic [OP_W-1:0]        in_op,
    output logic [OPND_W-1:0]      alu_a,
    output logic [OPND_W-1:0]      alu_b,
    output logic [OP_W-1:0]        alu_op,
    input  logic [RES_W-1:0]       alu_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RES_W-1:0]       out_data,
    output logic [OP_W-1:0]        out_op,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    opnd_t       r_alu_a;
    opnd_t       r_alu_b;
    op_t         r_alu_op;
    res_t        r_out_data;
    op_t         r_out_op;
    cmd_t        w_cmd;
    cmd_t        w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_capture;
    assign w_cmd = '{a: in_a, b: in_b, op: in_op};
    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (in_valid),
        .i_data  (w_cmd),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );
    assign in_ready  = !w_full;
    assign out_valid = r_state == HOLD;
    assign busy      = (r_state != IDLE) || !w_empty;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign out_data  = r_out_data;
    assign out_op    = r_out_op;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                w_pop  = !w_empty;
                w_next = w_empty ? IDLE : WAIT;
            end
            WAIT: begin
                w_capture = r_cnt == '0;
                w_next    = w_capture ? HOLD : WAIT;
            end
            HOLD:    w_next = out_ready ? IDLE : HOLD;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_out_data <= '0;
            r_out_op   <= '0;
        end else begin
            if (w_pop) begin
                r_alu_a  <= w_head.a;
                r_alu_b  <= w_head.b;
                r_alu_op <= w_head.op;
                r_cnt    <= 3'(ALU_LAT);
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                r_out_data <= alu_result;
                r_out_op   <= r_alu_op;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench with a registered ALU stub (op 0 = A+B, else A^B).
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  in_a = '0;
    logic [3:0]  in_b = '0;
    logic [2:0]  in_op = '0;
    logic        in_ready, out_valid, busy;
    logic [3:0]  alu_a, alu_b;
    logic [2:0]  alu_op, out_op;
    logic [7:0]  alu_result, out_data;
    logic [2:0]  fifo_count;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [10:0] sb [$];
    int          hs_t [$];

    alu_issue_stage #(.DEPTH(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_op(out_op),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) alu_result <= '0;
        else        alu_result <= (alu_op == 3'd0) ? {4'd0, alu_a} + {4'd0, alu_b} : {4'd0, alu_a ^ alu_b};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [7:0] r;
        r = (op == 3'd0) ? {4'd0, a} + {4'd0, b} : {4'd0, a ^ b};
        return {op, r};
    endfunction

    // Consumer side: every handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            hs_t.push_back(cyc);
            if (sb.size() == 0) chk("unexpected_result", 32'(out_data), 32'hDEAD);
            else                chk("result", 32'({out_op, out_data}), 32'(sb.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input bit acc);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        chk("in_ready", 32'(in_ready), 32'(acc));
        if (acc) sb.push_back(model(a, b, op));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid) chk(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        // first edge after release accepts; result 3 cycles later
        out_ready = 1'b1;
        send(4'd3, 4'd5, 3'd0, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'd3);
        chk("single_data", 32'(out_data), 32'h08);
        chk("single_op", 32'(out_op), 32'd0);
        wait_idle();
        // back-to-back pair, in order, 4 cycles apart
        hs_t.delete();
        send(4'd9, 4'd6, 3'd1, 1'b1);
        send(4'd15, 4'd15, 3'd0, 1'b1);
        wait_idle();
        chk("pair_count", 32'(hs_t.size()), 32'd2);
        if (hs_t.size() == 2) chk("pair_spacing", 32'(hs_t[1] - hs_t[0]), 32'd4);
        // fill while a result is held
        out_ready = 1'b0;
        send(4'd1, 4'd2, 3'd0, 1'b1);
        wait_valid("hold_timeout", n);
        for (int i = 0; i < 5; i++) send(4'(i + 4), 4'd3, 3'(i % 2), i < 4);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_data", 32'(out_data), 32'h03);
            chk("hold_op", 32'(out_op), 32'd0);
            chk("hold_alu_a", 32'(alu_a), 32'd1);
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        // full FIFO popped while a push is offered: push refused, in_ready rises next cycle
        in_valid = 1'b1;
        in_a = 4'd13;
        in_b = 4'd1;
        in_op = 3'd1;
        chk("pop_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("issue_alu_a", 32'(alu_a), 32'd4);
        chk("pop_count", 32'(fifo_count), 32'd3);
        chk("pop_in_ready_next", 32'(in_ready), 32'd1);
        send(4'd14, 4'd2, 3'd0, 1'b1);
        chk("refill_count", 32'(fifo_count), 32'd4);
        out_ready = 1'b1;
        wait_idle();
        // reset during WAIT with two queued
        out_ready = 1'b0;
        send(4'd7, 4'd9, 3'd1, 1'b1);
        send(4'd2, 4'd2, 3'd0, 1'b1);
        send(4'd3, 4'd3, 3'd0, 1'b1);
        chk("pre_rst_count", 32'(fifo_count), 32'd2);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rst_alu_b", 32'(alu_b), 32'd0);
        chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_out_op", 32'(out_op), 32'd0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("post_rst_valid", 32'(seen), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        send(4'd2, 4'd3, 3'd1, 1'b1);
        wait_idle();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
